// File: rtl/gc_ram_scheduler.sv
// gc_ram_scheduler
//   Time-slice arbiter that shares one single-read-port state SRAM among
//   PORTS controller-emulator channels. A channel is granted, its address
//   {channel, bit address} is driven to the SRAM, and the returned bit is
//   presented on data_out with a one-hot ack naming the channel it belongs to.
//
//   Pipeline (req/port_addr sampled at edge t):
//     edge t                  : grant register (index, address, valid)
//     edge t+1                : ram_addr / issue valid registered
//     edges t+2..t+1+LAT      : valid/index delay line matching SRAM latency
//     edge t+2+SRAM_LATENCY   : data_out <= ram_data, ack <= onehot(index)
//
//   Build option GC_RAM_SCHED_SKIP_IDLE_EN:
//     defined   - rotating priority among requesting channels; idle
//                 channels consume no slots.
//     undefined - fixed rotation 0,1,..,PORTS-1 from reset, one slot per
//                 cycle; req is ignored and every slot produces an ack.
//
//   Ports:
//     clk        system clock, rising edge
//     reset      asynchronous active-low reset
//     req        [PORTS]            per-channel read request (level)
//     port_addr  [PORTS*ADDR_BITS]  channel i address at [i*ADDR_BITS +: ADDR_BITS]
//     ram_addr   [PORT_BITS+ADDR_BITS] registered SRAM address {index, address}
//     ram_data   SRAM read bit, valid SRAM_LATENCY cycles after ram_addr
//     data_out   registered read bit, shared by all channels
//     ack        [PORTS] one-hot; ack[i] marks data_out as channel i's bit

// Per-channel acknowledge register: one lane per channel, so the one-hot
// decode is registered directly in each output bit.
module gc_ram_sched_lane #(
    parameter int PORT_BITS = 2,
    parameter int LANE      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vld,
    input  logic [PORT_BITS-1:0] idx,
    output logic                 ack
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ack <= 1'b0;
        else        ack <= vld && (idx == PORT_BITS'(LANE));
    end

endmodule

module gc_ram_scheduler #(
    parameter int PORTS        = 4,
    parameter int ADDR_BITS    = 6,
    parameter int SRAM_LATENCY = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [PORTS-1:0]                    req,
    input  logic [PORTS*ADDR_BITS-1:0]          port_addr,
    output logic [$clog2(PORTS)+ADDR_BITS-1:0]  ram_addr,
    input  logic                                ram_data,
    output logic                                data_out,
    output logic [PORTS-1:0]                    ack
);

    localparam int PORT_BITS = $clog2(PORTS);

    // Channel addresses viewed as an indexable packed array.
    logic [PORTS-1:0][ADDR_BITS-1:0] addr_arr;
    assign addr_arr = port_addr;

    // ------------------------------------------------------------------
    // Grant selection (combinational)
    // ------------------------------------------------------------------
    logic [PORT_BITS-1:0] last_grant;
    logic [PORT_BITS-1:0] sel_idx;
    logic                 sel_vld;

`ifdef GC_RAM_SCHED_SKIP_IDLE_EN
    logic [PORT_BITS-1:0] cand;

    // Scan from lowest priority (last_grant itself) to highest
    // (last_grant+1) so the highest-priority requester is written last.
    // Index arithmetic wraps naturally in PORT_BITS bits (PORTS is 2^n).
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = PORTS; k >= 1; k--) begin
            cand = last_grant + PORT_BITS'(k);
            if (req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end
`else
    // Legacy fixed rotation: every cycle is a slot for the next channel.
    logic unused_req;
    assign unused_req = ^req;
    assign sel_vld    = 1'b1;
    assign sel_idx    = last_grant + PORT_BITS'(1);
`endif

    // ------------------------------------------------------------------
    // Grant register: captures index and the channel's address at grant
    // time, so later port_addr changes or a dropped req cannot disturb the
    // in-flight read. last_grant resets to PORTS-1 so channel 0 goes first.
    // ------------------------------------------------------------------
    logic                 g_vld;
    logic [PORT_BITS-1:0] g_idx;
    logic [ADDR_BITS-1:0] g_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= PORT_BITS'(PORTS - 1);
            g_vld      <= 1'b0;
            g_idx      <= '0;
            g_addr     <= '0;
        end else begin
            g_vld <= sel_vld;
            if (sel_vld) begin
                last_grant <= sel_idx;
                g_idx      <= sel_idx;
                g_addr     <= addr_arr[sel_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue stage and valid/index delay line.
    // vld_pipe[0]/idx_pipe[0] are aligned with ram_addr; entry k is k cycles
    // later, so entry SRAM_LATENCY lines up with valid ram_data.
    // ram_addr only moves on a real issue; idle cycles hold the old address.
    // ------------------------------------------------------------------
    logic [SRAM_LATENCY:0]                vld_pipe;
    logic [SRAM_LATENCY:0][PORT_BITS-1:0] idx_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ram_addr <= '0;
            vld_pipe <= '0;
            idx_pipe <= '0;
        end else begin
            if (g_vld) ram_addr <= {g_idx, g_addr};
            vld_pipe[0] <= g_vld;
            idx_pipe[0] <= g_idx;
            for (int k = 1; k <= SRAM_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Return stage: shared data bit plus one registered ack per channel.
    // Reset clears the delay line, so in-flight reads never reach ack.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) data_out <= 1'b0;
        else        data_out <= ram_data;
    end

    generate
        for (genvar i = 0; i < PORTS; i++) begin : g_lane
            gc_ram_sched_lane #(
                .PORT_BITS (PORT_BITS),
                .LANE      (i)
            ) u_lane (
                .clk   (clk),
                .reset (reset),
                .vld   (vld_pipe[SRAM_LATENCY]),
                .idx   (idx_pipe[SRAM_LATENCY]),
                .ack   (ack[i])
            );
        end
    endgenerate

endmodule
